ext_info_gen: RTL and testbench

EXT_INFO_GEN -- requirements
Module: ext_info_gen

---
 rtl/ext_info_gen.sv | 205 ++++++++++++++++++++
 tb/tb_ext_info_gen.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ext_info_gen.sv
`default_nettype none
// ============================================================================
//  Module   : ext_info_gen
//  Purpose  : Extrinsic-information generator for a 4-bit symbol. On start,
//             captures soft outputs, systematic and a-priori LLRs, then per
//             bit computes S - sys - apri, optionally scales by 0.75,
//             saturates symmetrically to OUT_W bits and hands one word at a
//             time to the downstream interleaver with valid/ready.
//  Ports    : clk, rst (async, active-low), start,
//             soft_in1..4 [30:0] sign-magnitude, sys_in1..4 / apri_in1..4
//             [15:0] signed, ext_data [OUT_W-1:0], ext_idx [1:0], hard_bit,
//             ext_valid, ext_ready, busy, done.
//  Revision : 1.0 - initial release
// ============================================================================
module ext_info_gen #(
   parameter int unsigned OUT_W    = 16,
   parameter bit          SCALE_EN = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [30:0]             soft_in1,
   input  logic [30:0]             soft_in2,
   input  logic [30:0]             soft_in3,
   input  logic [30:0]             soft_in4,
   input  logic signed [15:0]      sys_in1,
   input  logic signed [15:0]      sys_in2,
   input  logic signed [15:0]      sys_in3,
   input  logic signed [15:0]      sys_in4,
   input  logic signed [15:0]      apri_in1,
   input  logic signed [15:0]      apri_in2,
   input  logic signed [15:0]      apri_in3,
   input  logic signed [15:0]      apri_in4,
   output logic signed [OUT_W-1:0] ext_data,
   output logic [1:0]              ext_idx,
   output logic                    hard_bit,
   output logic                    ext_valid,
   input  logic                    ext_ready,
   output logic                    busy,
   output logic                    done
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CALC  = 3'd1,
      SCALE = 3'd2,
      SAT   = 3'd3,
      OUT   = 3'd4,
      DONE  = 3'd5
   } state_t;

   // Symmetric clamp limits; the most negative code is never produced.
   localparam logic signed [32:0] MAX_POS = (33'sd1 <<< (OUT_W - 1)) - 33'sd1;
   localparam logic signed [32:0] MAX_NEG = -MAX_POS;

   state_t                    state_q, state_d;
   logic [1:0]                idx_q, idx_d;
   logic [30:0]               soft_q [4];
   logic [30:0]               soft_d [4];
   logic signed [15:0]        sys_q  [4];
   logic signed [15:0]        sys_d  [4];
   logic signed [15:0]        apri_q [4];
   logic signed [15:0]        apri_d [4];
   logic signed [32:0]        diff_q, diff_d;
   logic signed [32:0]        scl_q, scl_d;
   logic signed [OUT_W-1:0]   data_q, data_d;
   logic [1:0]                eidx_q, eidx_d;
   logic                      hard_q, hard_d;
   logic                      valid_q, valid_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;

   logic [30:0]               w_soft;
   logic signed [32:0]        w_mag;
   logic signed [32:0]        w_s;
   logic signed [32:0]        w_diff;
   logic signed [32:0]        w_scaled;
   logic signed [OUT_W-1:0]   w_sat;

   // Datapath for the currently selected bit.
   always_comb begin
      w_soft   = soft_q[idx_q];
      w_mag    = {3'b000, w_soft[29:0]};
      // A negative sign with zero magnitude negates to zero, as intended.
      w_s      = w_soft[30] ? -w_mag : w_mag;
      w_diff   = w_s - {{17{sys_q[idx_q][15]}}, sys_q[idx_q]}
                     - {{17{apri_q[idx_q][15]}}, apri_q[idx_q]};
      // 0.75 * x as x - floor(x/4).
      w_scaled = SCALE_EN ? (diff_q - (diff_q >>> 2)) : diff_q;
      if (scl_q > MAX_POS) begin
         w_sat = MAX_POS[OUT_W-1:0];
      end else if (scl_q < MAX_NEG) begin
         w_sat = MAX_NEG[OUT_W-1:0];
      end else begin
         w_sat = scl_q[OUT_W-1:0];
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      soft_d  = soft_q;
      sys_d   = sys_q;
      apri_d  = apri_q;
      diff_d  = diff_q;
      scl_d   = scl_q;
      data_d  = data_q;
      eidx_d  = eidx_q;
      hard_d  = hard_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               soft_d[0] = soft_in1;  soft_d[1] = soft_in2;
               soft_d[2] = soft_in3;  soft_d[3] = soft_in4;
               sys_d[0]  = sys_in1;   sys_d[1]  = sys_in2;
               sys_d[2]  = sys_in3;   sys_d[3]  = sys_in4;
               apri_d[0] = apri_in1;  apri_d[1] = apri_in2;
               apri_d[2] = apri_in3;  apri_d[3] = apri_in4;
               idx_d     = 2'd0;
               busy_d    = 1'b1;
               state_d   = CALC;
            end
         end
         CALC: begin
            diff_d  = w_diff;
            state_d = SCALE;
         end
         SCALE: begin
            scl_d   = w_scaled;
            state_d = SAT;
         end
         SAT: begin
            data_d  = w_sat;
            eidx_d  = idx_q;
            hard_d  = ~soft_q[idx_q][30];
            valid_d = 1'b1;
            state_d = OUT;
         end
         OUT: begin
            if (ext_ready) begin
               valid_d = 1'b0;
               if (idx_q == 2'd3) begin
                  done_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  state_d = CALC;
               end
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         idx_q   <= 2'd0;
         for (int i = 0; i < 4; i++) begin
            soft_q[i] <= '0;
            sys_q[i]  <= '0;
            apri_q[i] <= '0;
         end
         diff_q  <= '0;
         scl_q   <= '0;
         data_q  <= '0;
         eidx_q  <= 2'd0;
         hard_q  <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         soft_q  <= soft_d;
         sys_q   <= sys_d;
         apri_q  <= apri_d;
         diff_q  <= diff_d;
         scl_q   <= scl_d;
         data_q  <= data_d;
         eidx_q  <= eidx_d;
         hard_q  <= hard_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign ext_data  = data_q;
   assign ext_idx   = eidx_q;
   assign hard_bit  = hard_q;
   assign ext_valid = valid_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ext_info_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ext_info_gen
//  Purpose  : Directed self-checking bench for ext_info_gen. Two instances
//             share all inputs: u_sc (SCALE_EN=1) and u_ns (SCALE_EN=0).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ext_info_gen;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic [30:0] soft_in1, soft_in2, soft_in3, soft_in4;
   logic signed [15:0] sys_in1, sys_in2, sys_in3, sys_in4;
   logic signed [15:0] apri_in1, apri_in2, apri_in3, apri_in4;
   logic ext_ready = 1'b1;

   logic signed [15:0] ext_data, ns_data;
   logic [1:0]         ext_idx, ns_idx;
   logic               hard_bit, ns_hard, ext_valid, ns_valid;
   logic               busy, ns_busy, done, ns_done;

   int n_chk = 0;
   int n_err = 0;

   // Hand-computed expectations: frame A and frame B, scaled / unscaled / hard bit.
   int fa_sc [4] = '{525, -225, 32767, -32767};
   int fa_ns [4] = '{700, -300, 32767, -32767};
   int fb_sc [4] = '{32767, -9, 4, 8};
   int fb_ns [4] = '{32767, -13, 5, 10};
   int f_hb  [4] = '{1, 0, 1, 0};

   always #5 clk = ~clk;

   ext_info_gen u_sc (
      .clk(clk), .rst(rst), .start(start),
      .soft_in1(soft_in1), .soft_in2(soft_in2), .soft_in3(soft_in3), .soft_in4(soft_in4),
      .sys_in1(sys_in1), .sys_in2(sys_in2), .sys_in3(sys_in3), .sys_in4(sys_in4),
      .apri_in1(apri_in1), .apri_in2(apri_in2), .apri_in3(apri_in3), .apri_in4(apri_in4),
      .ext_data(ext_data), .ext_idx(ext_idx), .hard_bit(hard_bit),
      .ext_valid(ext_valid), .ext_ready(ext_ready), .busy(busy), .done(done)
   );

   ext_info_gen #(.OUT_W(16), .SCALE_EN(1'b0)) u_ns (
      .clk(clk), .rst(rst), .start(start),
      .soft_in1(soft_in1), .soft_in2(soft_in2), .soft_in3(soft_in3), .soft_in4(soft_in4),
      .sys_in1(sys_in1), .sys_in2(sys_in2), .sys_in3(sys_in3), .sys_in4(sys_in4),
      .apri_in1(apri_in1), .apri_in2(apri_in2), .apri_in3(apri_in3), .apri_in4(apri_in4),
      .ext_data(ns_data), .ext_idx(ns_idx), .hard_bit(ns_hard),
      .ext_valid(ns_valid), .ext_ready(ext_ready), .busy(ns_busy), .done(ns_done)
   );

   // Handshake / done monitor on the scaled instance.
   int       hs_cnt = 0;
   int       seq_err = 0;
   int       done_cnt = 0;
   logic [1:0] exp_idx = 2'd0;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         exp_idx <= 2'd0;
      end else begin
         if (ext_valid && ext_ready) begin
            hs_cnt <= hs_cnt + 1;
            if (ext_idx != exp_idx) seq_err <= seq_err + 1;
            exp_idx <= ext_idx + 2'd1;
         end
         if (done) done_cnt <= done_cnt + 1;
      end
   end

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_a();
      soft_in1 = 31'd1000;                soft_in2 = {1'b1, 30'd400};
      soft_in3 = {1'b0, 30'h2000_0000};   soft_in4 = {1'b1, 30'h2000_0000};
      sys_in1 = 16'sd200;  sys_in2 = -16'sd100; sys_in3 = 16'sd0; sys_in4 = 16'sd0;
      apri_in1 = 16'sd100; apri_in2 = 16'sd0;   apri_in3 = 16'sd0; apri_in4 = 16'sd0;
   endtask

   task automatic load_b();
      soft_in1 = 31'd0;             soft_in2 = {1'b1, 30'd13};
      soft_in3 = 31'd5;             soft_in4 = {1'b1, 30'd0};
      sys_in1 = 16'sh8000; sys_in2 = 16'sd0; sys_in3 = 16'sd0; sys_in4 = -16'sd10;
      apri_in1 = 16'sh8000; apri_in2 = 16'sd0; apri_in3 = 16'sd0; apri_in4 = 16'sd0;
   endtask

   // Pulse start and check that ext_valid first rises after edge k+3.
   task automatic pulse_start();
      start = 1'b1;
      tick();                       // edge k
      start = 1'b0;
      check("busy_after_start", int'(busy), 1);
      check("valid_k0", int'(ext_valid), 0);
      tick();
      check("valid_k1", int'(ext_valid), 0);
      tick();
      check("valid_k2", int'(ext_valid), 0);
      tick();
      check("valid_k3", int'(ext_valid), 1);
   endtask

   task automatic get_word(input int i, input int e_sc, input int e_ns, input int e_hb,
                           input int hold, input bit poke, input bit gap);
      int n;
      ext_ready = (hold == 0);
      n = 0;
      while (!ext_valid && n < 20) begin
         tick();
         n++;
      end
      check("valid_wait", int'(ext_valid), 1);
      check("idx", int'(ext_idx), i);
      check("data_sc", int'(ext_data), e_sc);
      check("data_ns", int'(ns_data), e_ns);
      check("hard", int'(hard_bit), e_hb);
      check("hard_ns", int'(ns_hard), e_hb);
      for (int h = 0; h < hold; h++) begin
         if (poke && h == 0) begin
            load_b();
            start = 1'b1;
         end
         tick();
         start = 1'b0;
         check("bp_valid", int'(ext_valid), 1);
         check("bp_idx", int'(ext_idx), i);
         check("bp_data", int'(ext_data), e_sc);
      end
      ext_ready = 1'b1;
      tick();                       // handshake edge
      check("valid_drop", int'(ext_valid), 0);
      if (gap) begin
         n = 0;
         while (!ext_valid && n < 10) begin
            tick();
            n++;
         end
         check("word_gap", n, 3);
      end
   endtask

   task automatic run_frame(input bit fb, input int hold1, input bit poke2);
      int hs0, dn0;
      hs0 = hs_cnt;
      dn0 = done_cnt;
      if (fb) load_b(); else load_a();
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         get_word(i, fb ? fb_sc[i] : fa_sc[i], fb ? fb_ns[i] : fa_ns[i], f_hb[i],
                  (i == 1) ? hold1 : ((i == 2 && poke2) ? 2 : 0),
                  (i == 2) && poke2, i < 3);
      end
      check("done_pulse", int'(done), 1);
      check("done_ns", int'(ns_done), 1);
      tick();
      check("done_clear", int'(done), 0);
      check("busy_clear", int'(busy), 0);
      check("hs_count", hs_cnt - hs0, 4);
      check("done_count", done_cnt - dn0, 1);
      check("hs_order", seq_err, 0);
   endtask

   initial begin
      int vcnt;
      load_a();
      #2;
      // Reset state
      check("rst_data", int'(ext_data), 0);
      check("rst_idx", int'(ext_idx), 0);
      check("rst_valid", int'(ext_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      tick();
      rst = 1'b1;
      tick();
      // ext_ready while idle has no effect
      check("idle_valid", int'(ext_valid), 0);

      // Basic frame, backpressure on word1, ignored start during word2
      run_frame(1'b0, 5, 1'b1);
      tick();
      check("no_restart", int'(busy), 0);

      // Frame B: saturation at negative input extremes, floor rounding, {1,0}
      run_frame(1'b1, 0, 1'b0);

      // Reset during OUT of word1
      load_a();
      pulse_start();
      get_word(0, fa_sc[0], fa_ns[0], f_hb[0], 0, 1'b0, 1'b1);
      ext_ready = 1'b0;
      tick();
      #2;
      rst = 1'b0;
      #1;
      check("ar_valid", int'(ext_valid), 0);
      check("ar_data", int'(ext_data), 0);
      check("ar_idx", int'(ext_idx), 0);
      check("ar_hard", int'(hard_bit), 0);
      check("ar_busy", int'(busy), 0);
      check("ar_done", int'(done), 0);
      check("ar_ns_data", int'(ns_data), 0);
      tick();
      rst = 1'b1;
      ext_ready = 1'b1;
      vcnt = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         vcnt += int'(ext_valid) + int'(done);
      end
      check("abort_quiet", vcnt, 0);

      run_frame(1'b1, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
